sqrt: RTL
=========

# sqrt

Iterative unsigned integer square root; the stage directly downstream of `mul`. It consumes a 16-bit product in the same `start_i`/`busy_o` handshake style and returns `floor(sqrt(x))` as an 8-bit result. It uses the shift-subtract digit-by-digit algorithm with no multiplier and resolves one result bit per clock. It is intended for `a*b`-then-root datapaths in the arithmetic unit.

## Interface
- No parameters; widths are fixed at 16-bit input and 8-bit root.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `x_bi`  in  16  unsigned radicand; sampled only on an accepted start.
- `start_i`  in  1  request; level-sampled, accepted only in IDLE.
- `busy_o`  out  1  high while a computation is in progress.
- `y_bo`  out  8  result `floor(sqrt(x))`; holds the last completed value.
- `rem_bo`  out  9  remainder `x - y*y`; present only with `SQRT_REM_EN`.

## Operation
- FSM states: IDLE and WORK.
- Internal registers:
  - `x_r[15:0]`: working remainder.
  - `part_r[15:0]`: partial root, in shifted form.
  - `m_r[15:0]`: one-hot position mask.
  - `cnt_r[3:0]`: iteration counter.
- IDLE with `start_i=1` at a rising edge:
  - Loads `x_r<=x_bi`, `part_r<=0`, `m_r<=16'h4000`, `cnt_r<=0`.
  - Sets `busy_o<=1` and moves to WORK.
- IDLE with `start_i=0`: all registers hold.
- WORK, one iteration per cycle, with `b = part_r | m_r`:
  - If `x_r >= b`: `x_r<=x_r-b` and `part_r<=(part_r>>1)|m_r`.
  - Otherwise: `part_r<=part_r>>1`.
  - Always: `m_r<=m_r>>2` and `cnt_r<=cnt_r+1`.
- Completion, on the 8th WORK cycle (`cnt_r==7`):
  - `y_bo` takes that cycle's new `part_r[7:0]`.
  - `rem_bo` takes that cycle's new `x_r[8:0]`.
  - `busy_o<=0` and the state returns to IDLE.
- `start_i` is ignored while in WORK. `x_bi` may change freely after acceptance.
- `start_i` held high continuously: a new computation is accepted on the first cycle back in IDLE. `y_bo` stays stable at the last result throughout.
- Arithmetic bounds:
  - Result is at most 255.
  - Remainder is at most `2*y`, i.e. at most 510, so 9 bits suffice.
  - The subtraction never underflows because it is guarded by the compare.
- Reset at any time, including mid-WORK: the computation is aborted, the state goes to IDLE, and all outputs clear on that edge.

## Timing
- Reset values: `busy_o=0`, `y_bo=0`, `rem_bo=0`, state IDLE.
- Start accepted at edge N → `busy_o` is high from edge N through edge N+8.
- At edge N+8: `busy_o` falls and the new `y_bo`/`rem_bo` become valid.
- Latency is exactly 8 cycles from acceptance to result, independent of the data.
- Earliest next acceptance is edge N+9, giving a throughput of 1 result per 9 cycles.
- `rst_i` and `start_i` asserted in the same cycle: reset wins and no start is accepted.
- `y_bo` never glitches or shows intermediate values; it changes only at completion or reset.

## Configuration
- Macro: `SQRT_REM_EN`.
- Defined:
  - `rem_bo[8:0]` exists as a port.
  - It is registered at completion alongside `y_bo` and cleared by reset.
- Undefined:
  - The `rem_bo` port is absent.
  - `x_r` is still used internally for the compare; no other behaviour changes.

## Test plan
- Reset, then `x_bi=0` with a start pulse → `busy_o` high for 8 cycles, then `y_bo=0`, `rem_bo=0`.
- `x_bi=225` (the `mul` output for 15*15) → `y_bo=15`, `rem_bo=0`, and `busy_o` falls exactly 8 edges after acceptance.
- `x_bi=200` → `y_bo=14`, `rem_bo=4`. Then `x_bi=65535` → `y_bo=255`, `rem_bo=510`.
- Start with `x_bi=100`; during WORK pulse `start_i` with `x_bi=50000` → the second start is ignored and `y_bo=10`. `start_i` held high with `x_bi=49` → repeated results of 7, with `busy_o` low for exactly one cycle between runs.
- Start `x_bi=1024` after a prior result of 15; assert `rst_i` at the 4th WORK cycle → `busy_o=0`, `y_bo=0`, `rem_bo=0` on that edge. The next start then yields 32.
- Sweep `x_bi=i*i` for i=0..255 and random x values → `y_bo*y_bo <= x < (y_bo+1)^2`, and `rem_bo=x-y_bo^2`.

Source files
------------

// File: rtl/sqrt.sv
// Iterative unsigned square root: 16-bit radicand -> 8-bit floor root, one root bit per clock.
// Optional remainder output rem_bo is enabled by defining SQRT_REM_EN.
module sqrt (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] x_bi,
    input  logic        start_i,
    output logic        busy_o,
    output logic [7:0]  y_bo
`ifdef SQRT_REM_EN
    ,
    output logic [8:0]  rem_bo
`endif
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WORK = 1'b1
    } state_t;

    state_t      state_r, state_n_s;
    logic [15:0] x_r, x_n_s;
    logic [15:0] part_r, part_n_s;
    logic [15:0] m_r, m_n_s;
    logic [3:0]  cnt_r, cnt_n_s;
    logic        busy_r, busy_n_s;
    logic [7:0]  y_r, y_n_s;
    logic [15:0] b_s;
`ifdef SQRT_REM_EN
    logic [8:0]  rem_r, rem_n_s;
`endif

    // Next-state, datapath and result computation for one digit per cycle.
    always_comb begin
        state_n_s = state_r;
        x_n_s     = x_r;
        part_n_s  = part_r;
        m_n_s     = m_r;
        cnt_n_s   = cnt_r;
        busy_n_s  = busy_r;
        y_n_s     = y_r;
`ifdef SQRT_REM_EN
        rem_n_s   = rem_r;
`endif
        b_s       = part_r | m_r;

        case (state_r)
            IDLE: begin
                if (start_i) begin
                    x_n_s     = x_bi;
                    part_n_s  = 16'h0000;
                    m_n_s     = 16'h4000;
                    cnt_n_s   = 4'd0;
                    busy_n_s  = 1'b1;
                    state_n_s = WORK;
                end else begin
                    state_n_s = IDLE;
                end
            end
            WORK: begin
                // part_r and m_r never overlap, so OR is the trial sum root+bit.
                if (x_r >= b_s) begin
                    x_n_s    = x_r - b_s;
                    part_n_s = (part_r >> 1) | m_r;
                end else begin
                    part_n_s = part_r >> 1;
                end
                m_n_s   = m_r >> 2;
                cnt_n_s = cnt_r + 4'd1;
                if (cnt_r == 4'd7) begin
                    y_n_s     = part_n_s[7:0];
`ifdef SQRT_REM_EN
                    rem_n_s   = x_n_s[8:0];
`endif
                    busy_n_s  = 1'b0;
                    state_n_s = IDLE;
                end else begin
                    state_n_s = WORK;
                end
            end
            default: begin
                busy_n_s  = 1'b0;
                state_n_s = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset that aborts any computation.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            x_r     <= 16'h0000;
            part_r  <= 16'h0000;
            m_r     <= 16'h0000;
            cnt_r   <= 4'd0;
            busy_r  <= 1'b0;
            y_r     <= 8'd0;
`ifdef SQRT_REM_EN
            rem_r   <= 9'd0;
`endif
        end else begin
            state_r <= state_n_s;
            x_r     <= x_n_s;
            part_r  <= part_n_s;
            m_r     <= m_n_s;
            cnt_r   <= cnt_n_s;
            busy_r  <= busy_n_s;
            y_r     <= y_n_s;
`ifdef SQRT_REM_EN
            rem_r   <= rem_n_s;
`endif
        end
    end

    assign busy_o = busy_r;
    assign y_bo   = y_r;
`ifdef SQRT_REM_EN
    assign rem_bo = rem_r;
`endif

endmodule
